// File: rtl/config_chain_loader_pkg.sv
// Shared definitions for the serial config-chain loader.
// Holds the FSM state encoding, default chain/word sizes and the
// helper used to size counters so they can hold their terminal value.
package cfg_loader_pkg;

  localparam int unsigned CHAIN_LEN_DEF = 32'd41;
  localparam int unsigned WORD_W_DEF    = 32'd32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLR0     = 3'd1,
    CLR1     = 3'd2,
    FETCH    = 3'd3,
    SHIFT_LO = 3'd4,
    SHIFT_HI = 3'd5,
    DONE     = 3'd6
  } state_e;

  // Bits needed to represent values 0..max_val inclusive (never less than 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val < 32'd1) begin
      return 32'd1;
    end else begin
      return $clog2(max_val + 32'd1);
    end
  endfunction

endpackage

// File: rtl/config_chain_loader_if.sv
// Bitstream word handshake between a word source and the loader.
//   cfg_data  : bitstream word, bit 0 shifted first
//   cfg_valid : source has a word on cfg_data
//   cfg_ready : loader takes the word this cycle
// master = word source, slave = loader.
interface config_chain_loader_if #(
  parameter int unsigned WORD_W = 32'd32
) ();

  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);

endinterface

// File: rtl/config_chain_loader_serializer.sv
// cfg_word_serializer: word shift register plus wrapping bit index.
//   clk, reset : clock, synchronous active-low reset
//   load       : capture word, restart bit index
//   shift      : shift right by one, advance bit index (wraps at WORD_W)
//   word       : incoming bitstream word
//   next_lsb   : bit 0 the register will hold after this edge, so the
//                caller can register config_in on the same edge
//   last_bit   : current bit is the last one of the word
module cfg_word_serializer
  import cfg_loader_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] word,
  output logic              next_lsb,
  output logic              last_bit
);

  localparam int unsigned IDX_W = cnt_width(WORD_W - 32'd1);

  logic [WORD_W-1:0] shift_r;
  logic [IDX_W-1:0]  bit_idx_r;

  // Shift register and bit index update.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_r   <= '0;
      bit_idx_r <= '0;
    end else if (load) begin
      shift_r   <= word;
      bit_idx_r <= '0;
    end else if (shift) begin
      shift_r   <= {1'b0, shift_r[WORD_W-1:1]};
      bit_idx_r <= last_bit ? '0 : bit_idx_r + IDX_W'(1);
    end else begin
      shift_r   <= shift_r;
      bit_idx_r <= bit_idx_r;
    end
  end

  // Look-ahead of bit 0 so config_in lines up with the register contents.
  always_comb begin
    next_lsb = shift_r[0];
    if (load) begin
      next_lsb = word[0];
    end else if (shift) begin
      next_lsb = shift_r[1];
    end else begin
      next_lsb = shift_r[0];
    end
  end

  assign last_bit = (bit_idx_r == IDX_W'(WORD_W - 32'd1));

endmodule

// File: rtl/config_chain_loader.sv
// config_chain_loader: streams a bitstream into a serial config chain.
//   clk, reset   : clock, synchronous active-low reset
//   start, abort : begin a load (IDLE only) / cancel a load in progress
//   cfg          : word handshake (slave side)
//   config_clk   : shift strobe, config_reset: chain clear, config_in: data
//   config_out   : chain tail; must read 0 while loading a cleared chain
//   busy, done, err, run : status (err sticky until next start)
// Each bit takes two cycles: SHIFT_LO presents data with the strobe low and
// checks the tail, SHIFT_HI raises the strobe.
module config_chain_loader
  import cfg_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int unsigned WORD_W    = WORD_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic abort,
  config_chain_loader_if.slave cfg,
  output logic config_clk,
  output logic config_reset,
  output logic config_in,
  input  logic config_out,
  output logic busy,
  output logic done,
  output logic err,
  output logic run
);

  localparam int unsigned CNT_W = cnt_width(CHAIN_LEN);

  state_e           state_r;
  logic [CNT_W-1:0] bit_cnt_r;
  logic             cfg_ready_r;
  logic             load_s;
  logic             shift_s;
  logic             next_lsb_s;
  logic             last_bit_s;
  logic             chain_full_s;

  assign cfg.cfg_ready = cfg_ready_r;

  // Abort wins over the handshake, so the word is not captured on an abort.
  assign load_s       = (state_r == FETCH) && cfg.cfg_valid && !abort;
  assign shift_s      = (state_r == SHIFT_HI) && !abort;
  // The bit currently in SHIFT_HI is the final chain bit.
  assign chain_full_s = (bit_cnt_r == CNT_W'(CHAIN_LEN - 32'd1));

  cfg_word_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .shift    (shift_s),
    .word     (cfg.cfg_data),
    .next_lsb (next_lsb_s),
    .last_bit (last_bit_s)
  );

  // Load sequencer; outputs are registered together with the state they belong to.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= IDLE;
      bit_cnt_r    <= '0;
      cfg_ready_r  <= 1'b0;
      config_clk   <= 1'b0;
      config_reset <= 1'b0;
      config_in    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      run          <= 1'b0;
    end else if (abort && (state_r != IDLE)) begin
      // err deliberately kept so the cause stays visible after the cancel.
      state_r      <= IDLE;
      cfg_ready_r  <= 1'b0;
      config_clk   <= 1'b0;
      config_reset <= 1'b0;
      config_in    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      run          <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r      <= CLR0;
            bit_cnt_r    <= '0;
            busy         <= 1'b1;
            err          <= 1'b0;
            run          <= 1'b0;
            config_reset <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        CLR0: begin
          state_r <= CLR1;
        end
        CLR1: begin
          state_r      <= FETCH;
          config_reset <= 1'b0;
          cfg_ready_r  <= 1'b1;
        end
        FETCH: begin
          if (cfg.cfg_valid) begin
            state_r     <= SHIFT_LO;
            cfg_ready_r <= 1'b0;
            config_in   <= next_lsb_s;
          end else begin
            state_r <= FETCH;
          end
        end
        SHIFT_LO: begin
          // A cleared chain returns zeros until fully loaded; a 1 is corruption.
          if (config_out) begin
            err <= 1'b1;
          end else begin
            err <= err;
          end
          state_r    <= SHIFT_HI;
          config_clk <= 1'b1;
        end
        SHIFT_HI: begin
          config_clk <= 1'b0;
          bit_cnt_r  <= bit_cnt_r + CNT_W'(1);
          if (chain_full_s) begin
            state_r <= DONE;
            done    <= 1'b1;
            run     <= ~err;
          end else if (last_bit_s) begin
            state_r     <= FETCH;
            cfg_ready_r <= 1'b1;
          end else begin
            state_r   <= SHIFT_LO;
            config_in <= next_lsb_s;
          end
        end
        DONE: begin
          state_r   <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          config_in <= 1'b0;
        end
        default: begin
          state_r      <= IDLE;
          cfg_ready_r  <= 1'b0;
          config_clk   <= 1'b0;
          config_reset <= 1'b0;
          config_in    <= 1'b0;
          busy         <= 1'b0;
          done         <= 1'b0;
          run          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_chain_loader.sv
// Self-checking bench for config_chain_loader (CHAIN_LEN=41, WORD_W=32).
// Expected values come from a word-level model: the chain receives the first
// 41 bits of the word stream LSB-first, a load lasts 2 + words + 2*bits cycles
// plus stall cycles, and a tail 1 during a bit's low phase flags an error.
module tb_config_chain_loader;

  localparam int CHAIN_LEN = 41;
  localparam int WORD_W    = 32;
  localparam int NWORDS    = 2;

  logic clk = 1'b0;
  logic reset, start, abort, config_out;
  logic config_clk, config_reset, config_in, busy, done, err, run;

  config_chain_loader_if #(.WORD_W(WORD_W)) cfg_if ();

  config_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .cfg          (cfg_if),
    .config_clk   (config_clk),
    .config_reset (config_reset),
    .config_in    (config_in),
    .config_out   (config_out),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .run          (run)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    int          st0;
    int          st1;
    int          fault_bit;
    int          restart_at;
    int          exp_done;
    logic        exp_run;
    logic        exp_err;
  } vec_t;

  // Results of the most recent run_load call.
  int                   r_done_cyc;
  int                   r_rises;
  int                   r_rst_cnt;
  int                   r_err_rise;
  logic                 r_stall_ok;
  logic                 r_run;
  logic                 r_err;
  logic                 r_after_done;
  logic                 r_after_busy;
  logic [CHAIN_LEN-1:0] r_seq;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: chain receives stream bit i = word[i / WORD_W][i % WORD_W].
  function automatic logic [CHAIN_LEN-1:0] model_bits(input logic [31:0] w0, input logic [31:0] w1);
    logic [31:0] ws [NWORDS];
    logic [CHAIN_LEN-1:0] b;
    ws[0] = w0;
    ws[1] = w1;
    for (int i = 0; i < CHAIN_LEN; i++) b[i] = ws[i / WORD_W][i % WORD_W];
    return b;
  endfunction

  function automatic int model_cycles(input int stall_total);
    return 2 + (CHAIN_LEN + WORD_W - 1) / WORD_W + 2 * CHAIN_LEN + stall_total;
  endfunction

  // Drive one complete load and record what the chain side saw.
  task automatic run_load(input logic [31:0] w0, input logic [31:0] w1, input int st0, input int st1,
                          input int fault_bit, input int restart_at, input string tag);
    logic [31:0] words [NWORDS];
    int   stall_left [NWORDS];
    int   widx;
    logic prev_clk;
    logic accept;
    words[0] = w0; words[1] = w1;
    stall_left[0] = st0; stall_left[1] = st1;
    widx = 0; prev_clk = 1'b0;
    r_done_cyc = -1; r_rises = 0; r_rst_cnt = 0; r_err_rise = -1; r_stall_ok = 1'b1;
    r_seq = '0; r_run = 1'b0; r_err = 1'b0;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = $urandom;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " busy@0"}, {63'd0, busy}, 64'd1);
    chk({tag, " err_cleared@0"}, {63'd0, err}, 64'd0);
    for (int c = 0; c < 400 && r_done_cyc < 0; c++) begin
      if (config_reset) r_rst_cnt++;
      if (config_clk && !prev_clk) begin
        if (r_rises < CHAIN_LEN) r_seq[r_rises] = config_in;
        r_rises++;
      end
      prev_clk = config_clk;
      if (cfg_if.cfg_ready && config_clk) r_stall_ok = 1'b0;
      if (err && r_err_rise < 0) r_err_rise = r_rises;
      if (done) begin
        r_done_cyc = c;
        r_run = run;
        r_err = err;
      end
      config_out = (fault_bit >= 0) && (r_rises == fault_bit) && busy;
      start = (c == restart_at);
      if (cfg_if.cfg_ready && widx < NWORDS) begin
        if (stall_left[widx] > 0) begin
          stall_left[widx]--;
          cfg_if.cfg_valid = 1'b0;
          cfg_if.cfg_data  = $urandom;
        end else begin
          cfg_if.cfg_valid = 1'b1;
          cfg_if.cfg_data  = words[widx];
        end
      end else begin
        cfg_if.cfg_valid = 1'($urandom_range(1, 0));
        cfg_if.cfg_data  = $urandom;
      end
      accept = cfg_if.cfg_ready && cfg_if.cfg_valid;
      if (r_done_cyc < 0) begin
        tick();
        if (accept) widx++;
      end
    end
    config_out = 1'b0;
    start = 1'b0;
    tick();
    r_after_done = done;
    r_after_busy = busy;
  endtask

  task automatic check_load(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                            input int exp_done, input logic exp_run, input logic exp_err, input int fault_bit);
    chk({tag, " done_cycle"}, 64'(r_done_cyc), 64'(exp_done));
    chk({tag, " run"}, {63'd0, r_run}, {63'd0, exp_run});
    chk({tag, " err"}, {63'd0, r_err}, {63'd0, exp_err});
    chk({tag, " config_in_seq"}, 64'(r_seq), 64'(model_bits(w0, w1)));
    chk({tag, " clk_rises"}, 64'(r_rises), 64'(CHAIN_LEN));
    chk({tag, " clr_cycles"}, 64'(r_rst_cnt), 64'd2);
    chk({tag, " clk_low_in_fetch"}, {63'd0, r_stall_ok}, 64'd1);
    chk({tag, " err_at_bit"}, 64'(r_err_rise), (fault_bit < 0) ? 64'(-1) : 64'(fault_bit + 1));
    chk({tag, " done_one_cycle"}, {63'd0, r_after_done}, 64'd0);
    chk({tag, " idle_after_done"}, {63'd0, r_after_busy}, 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " outputs"},
        {56'd0, cfg_if.cfg_ready, config_clk, config_reset, config_in, busy, done, err, run}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [5];
    logic [31:0] rw0, rw1;
    int rs0, rs1, rf;

    vecs[0] = '{32'hA5A5A5A5, 32'h000001FF, 0, 0,  -1, -1, 86, 1'b1, 1'b0};
    vecs[1] = '{32'hA5A5A5A5, 32'h000001FF, 0, 10, -1, -1, 96, 1'b1, 1'b0};
    vecs[2] = '{32'hA5A5A5A5, 32'h000001FF, 0, 0,  7,  -1, 86, 1'b0, 1'b1};
    vecs[3] = '{32'h12345678, 32'hFFFFFABC, 3, 0,  -1, 40, 89, 1'b1, 1'b0};
    vecs[4] = '{32'h80000001, 32'h00000100, 0, 0,  -1, -1, 86, 1'b1, 1'b0};

    reset = 1'b0; start = 1'b0; abort = 1'b0; config_out = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_data = '0;
    repeat (3) tick();
    chk_all_zero("reset_state");
    reset = 1'b1;
    tick();
    chk_all_zero("idle_after_reset");

    // Table rows run back-to-back: each start follows the previous done's IDLE cycle.
    for (int i = 0; i < 5; i++) begin
      run_load(vecs[i].w0, vecs[i].w1, vecs[i].st0, vecs[i].st1, vecs[i].fault_bit,
               vecs[i].restart_at, $sformatf("row%0d", i));
      check_load($sformatf("row%0d", i), vecs[i].w0, vecs[i].w1, vecs[i].exp_done,
                 vecs[i].exp_run, vecs[i].exp_err, vecs[i].fault_bit);
    end

    // Randomised loads checked against the word-level model.
    for (int k = 0; k < 6; k++) begin
      rw0 = $urandom; rw1 = $urandom;
      rs0 = $urandom_range(5, 0); rs1 = $urandom_range(5, 0);
      rf  = ($urandom_range(1, 0) == 0) ? -1 : int'($urandom_range(CHAIN_LEN - 1, 0));
      run_load(rw0, rw1, rs0, rs1, rf, -1, $sformatf("rand%0d", k));
      check_load($sformatf("rand%0d", k), rw0, rw1, model_cycles(rs0 + rs1), rf < 0, rf >= 0, rf);
    end

    // Abort at cycle 20 after a tail error: IDLE at 21, err kept, no done.
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_data = 32'hA5A5A5A5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      config_out = (c >= 5);
      tick();
    end
    config_out = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort idle", {60'd0, cfg_if.cfg_ready, config_clk, config_reset, busy}, 64'd0);
    chk("abort no_done_run", {62'd0, done, run}, 64'd0);
    chk("abort err_kept", {63'd0, err}, 64'd1);
    begin
      int seen_done = 0;
      for (int c = 0; c < 5; c++) begin
        tick();
        if (done || busy) seen_done++;
      end
      chk("abort stays_idle", 64'(seen_done), 64'd0);
    end
    run_load(32'hA5A5A5A5, 32'h000001FF, 0, 0, -1, -1, "post_abort");
    check_load("post_abort", 32'hA5A5A5A5, 32'h000001FF, 86, 1'b1, 1'b0, -1);

    // Reset at cycle 30 mid-load, with a stray start at cycle 10.
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_data = 32'h5A5A5A5A;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 29; c++) begin
      start = (c == 9);
      abort = (c == 28);
      tick();
    end
    start = 1'b1;
    reset = 1'b0;
    tick();
    chk_all_zero("midload_reset");
    start = 1'b0; abort = 1'b0;
    reset = 1'b1;
    tick();
    chk_all_zero("after_midload_reset");
    run_load(32'h0F0F0F0F, 32'h00000055, 0, 0, -1, -1, "post_reset");
    check_load("post_reset", 32'h0F0F0F0F, 32'h00000055, 86, 1'b1, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/config_chain_loader.md
CONFIG_CHAIN_LOADER -- requirements
Module: config_chain_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 41, meaning the number of config bits in the target serial config chain.
REQ-002 SHALL have parameter WORD_W, default 32, meaning the width of the bitstream word input.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is synchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: pulse that begins a load; sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1 bit: cancels a load in progress.
REQ-007 SHALL have port cfg_data, input, WORD_W bits: bitstream word; bit 0 is shifted first.
REQ-008 SHALL have port cfg_valid, input, 1 bit: cfg_data is valid.
REQ-009 SHALL have port cfg_ready, output, 1 bit: the loader accepts a word this cycle.
REQ-010 SHALL have port config_clk, output, 1 bit: registered shift strobe to the chain.
REQ-011 SHALL have port config_reset, output, 1 bit: registered, active-high chain clear.
REQ-012 SHALL have port config_in, output, 1 bit: registered serial data to the chain head.
REQ-013 SHALL have port config_out, input, 1 bit: serial data returned from the chain tail.
REQ-014 SHALL have ports busy, done and err, outputs, 1 bit each: load active; one-cycle completion pulse; chain-integrity error (sticky until next start).
REQ-015 SHALL have port run, output, 1 bit: fabric configured and may execute.

Function
REQ-016 SHALL implement the FSM states IDLE, CLR0, CLR1, FETCH, SHIFT_LO, SHIFT_HI and DONE.
REQ-017 SHALL, in IDLE with start=1, clear err and run and go to CLR0; busy=1 from the next cycle.
REQ-018 SHALL drive config_reset=1 in CLR0 and CLR1, and 0 in all other states; CLR0 goes to CLR1, CLR1 goes to FETCH.
REQ-019 SHALL assert cfg_ready only in FETCH; on cfg_valid&cfg_ready, latch cfg_data into the shift register and go to SHIFT_LO.
REQ-020 SHALL, in SHIFT_LO, drive config_clk=0 and config_in=shift register bit 0, and sample config_out; a sampled 1 sets err.
REQ-021 SHALL, in SHIFT_HI, drive config_clk=1 with config_in held, then shift the register right and increment bit_cnt.
REQ-022 SHALL, after SHIFT_HI, go to DONE if bit_cnt==CHAIN_LEN; else to FETCH if all WORD_W bits of the word are used; else to SHIFT_LO.
REQ-023 SHALL ignore the unused upper bits of the final word (CHAIN_LEN mod WORD_W != 0).
REQ-024 SHALL, in DONE, pulse done for one cycle, set run=!err, drive config_clk=0, and return to IDLE.
REQ-025 SHALL, on abort=1 in any non-IDLE state, go to IDLE next cycle with config_clk=0, config_reset=0, run=0, done=0 and err unchanged; abort has priority over start and the handshake.
REQ-026 SHALL ignore start while busy, and SHALL not accept cfg_valid outside FETCH.
REQ-027 SHALL hold state, with config_clk low, while in FETCH with cfg_valid=0 (stall).
REQ-028 SHALL keep bit_cnt wide enough for CHAIN_LEN with no wrap; the word-bit index SHALL wrap at WORD_W.
REQ-029 SHALL take exactly 2 + ceil(CHAIN_LEN/WORD_W) + 2*CHAIN_LEN cycles from start to done with cfg_valid held high.

Reset
REQ-030 SHALL, with reset=0 at a clk edge, enter IDLE with all outputs 0 (cfg_ready, config_clk, config_reset, config_in, busy, done, err, run) and counters 0.
REQ-031 SHALL let reset mid-load take priority over abort, start and the handshake; the chain contents are then undefined and run stays 0.

Structure
REQ-032 SHALL place the state enum, the default CHAIN_LEN/WORD_W and the counter-width function in package cfg_loader_pkg.
REQ-033 SHALL implement the word shift register and bit index as one sub-module, cfg_word_serializer; the FSM stays in the top.

Verification
REQ-034 SHALL cover a nominal load: CHAIN_LEN=41, WORD_W=32, valid always high, words 0xA5A5A5A5 and 0x1FF -> done at cycle 86, run=1, err=0, the config_in sequence equals the 41 LSB-first bits, and 41 config_clk rising edges.
REQ-035 SHALL cover a stall: cfg_valid low for 10 cycles before word 2 -> config_clk stays low throughout, and done arrives at cycle 96.
REQ-036 SHALL cover a chain fault: config_out forced 1 at bit 7 -> err=1 from that cycle, done pulses, run=0.
REQ-037 SHALL cover abort: abort at cycle 20 -> IDLE at cycle 21, outputs 0 and no done; a following start gives a clean load.
REQ-038 SHALL cover a mid-load reset: reset=0 at cycle 30 -> all outputs 0 next edge, and start during the load is ignored.
REQ-039 SHALL cover back-to-back loads: start in the cycle after done -> the second load completes in 86 cycles.
